max_pool_ctrl: RTL

Sequencing controller for floating-point max pooling over a multi-channel feature map in on-chip memory. It walks every output position and its window, issues one memory read per cycle, and folds samples through the shared `fp_comp` comparator into a running maximum. Each result is emitted on a valid/ready stream. It sits between the feature-map buffer and the next layer's input stage, and replaces the fully parallel single-channel pooling array when area matters more than latency.

---
 rtl/max_pool_pkg.sv | 25 ++
 rtl/fp_comp.sv | 31 +++
 rtl/max_pool_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/max_pool_pkg.sv
// Shared types and helpers for the max pooling controller.
// FSM state encoding, fp word type and index-width helpers.
package max_pool_pkg;

  localparam int FP_WIDTH = 32;

  typedef logic [FP_WIDTH-1:0] fp_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    OUT,
    DONE
  } state_t;

  function automatic int out_dim(int mat, int win, int stride);
    return (mat - win) / stride + 1;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_comp.sv
// IEEE-754 magnitude comparator: AIsGreater when A > B strictly.
// Sign-magnitude ordering; +0 ranks above -0, NaN is not special-cased.
module fp_comp #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 AIsGreater
);

  logic                 sa;
  logic                 sb;
  logic [DATAWIDTH-2:0] ma;
  logic [DATAWIDTH-2:0] mb;

  assign sa = A[DATAWIDTH-1];
  assign sb = B[DATAWIDTH-1];
  assign ma = A[DATAWIDTH-2:0];
  assign mb = B[DATAWIDTH-2:0];

  always_comb begin
    AIsGreater = 1'b0;
    unique case ({sa, sb})
      2'b01:   AIsGreater = 1'b1;
      2'b10:   AIsGreater = 1'b0;
      2'b00:   AIsGreater = ma > mb;
      default: AIsGreater = ma < mb;
    endcase
  end

endmodule

// File: rtl/max_pool_ctrl.sv
// Sequential max pooling controller: one read per cycle, shared fp_comp.
// Define MAX_POOL_CTRL_PERF_EN to add the perf_cycles busy counter.
module max_pool_ctrl
  import max_pool_pkg::*;
#(
  parameter int DATAWIDTH        = 32,
  parameter int MAT_DIMENSION    = 27,
  parameter int WINDOW_DIMENSION = 3,
  parameter int STRIDE           = 2,
  parameter int CHANNELS         = 1,
  parameter int OUTPUT_DIMENSION =
    out_dim(MAT_DIMENSION, WINDOW_DIMENSION, STRIDE),
  parameter int ADDR_WIDTH       =
    $clog2(CHANNELS * MAT_DIMENSION * MAT_DIMENSION),
  localparam int CW = idx_w(CHANNELS),
  localparam int OW = idx_w(OUTPUT_DIMENSION),
  localparam int WW = idx_w(WINDOW_DIMENSION)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0]  rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic [CW-1:0]         out_ch,
  output logic [OW-1:0]         out_row,
  output logic [OW-1:0]         out_col
`ifdef MAX_POOL_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  typedef logic [ADDR_WIDTH-1:0] aw_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] ch;
  logic [OW-1:0] row;
  logic [OW-1:0] col;
  logic [WW-1:0] wr;
  logic [WW-1:0] wc;

  logic win_last;
  logic pos_last;
  logic accept;
  logic hs;
  logic rd_q;
  logic first_q;
  logic gt;

  logic [DATAWIDTH-1:0] mx;

  assign win_last = (wr == WW'(WINDOW_DIMENSION - 1))
                 && (wc == WW'(WINDOW_DIMENSION - 1));
  assign pos_last = (ch == CW'(CHANNELS - 1))
                 && (row == OW'(OUTPUT_DIMENSION - 1))
                 && (col == OW'(OUTPUT_DIMENSION - 1));
  assign accept = (state == IDLE) && start;
  assign hs     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (win_last) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = pos_last ? DONE : SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == SCAN):  begin busy = 1'b1; rd_en = 1'b1; end
      (state == DRAIN): busy = 1'b1;
      (state == OUT):   begin busy = 1'b1; out_valid = 1'b1; end
      (state == DONE):  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
      wr  <= '0;
      wc  <= '0;
    end else if (accept) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
      wr  <= '0;
      wc  <= '0;
    end else begin
      if (rd_en) begin
        if (wc == WW'(WINDOW_DIMENSION - 1)) begin
          wc <= '0;
          if (wr == WW'(WINDOW_DIMENSION - 1)) wr <= '0;
          else                                 wr <= wr + WW'(1);
        end else begin
          wc <= wc + WW'(1);
        end
      end
      if (hs) begin
        if (col == OW'(OUTPUT_DIMENSION - 1)) begin
          col <= '0;
          if (row == OW'(OUTPUT_DIMENSION - 1)) begin
            row <= '0;
            if (ch == CW'(CHANNELS - 1)) ch <= '0;
            else                         ch <= ch + CW'(1);
          end else begin
            row <= row + OW'(1);
          end
        end else begin
          col <= col + OW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_addr = '0;
    if (rd_en)
      rd_addr = aw_t'(ch) * aw_t'(MAT_DIMENSION * MAT_DIMENSION)
              + (aw_t'(row) * aw_t'(STRIDE) + aw_t'(wr))
                * aw_t'(MAT_DIMENSION)
              + aw_t'(col) * aw_t'(STRIDE) + aw_t'(wc);
  end

  fp_comp #(
    .DATAWIDTH (DATAWIDTH)
  ) u_comp (
    .A          (mx),
    .B          (rd_data),
    .AIsGreater (gt)
  );

  // First sample seeds the max; ties take the new sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      mx      <= '0;
    end else begin
      rd_q    <= rd_en;
      first_q <= rd_en && (wr == '0) && (wc == '0);
      if (rd_q && (first_q || !gt)) mx <= rd_data;
    end
  end

  assign out_data = mx;
  assign out_ch   = ch;
  assign out_row  = row;
  assign out_col  = col;

`ifdef MAX_POOL_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy)   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
